// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   - state_t      : responder FSM states (IDLE / BUSY / DONE)
//   - WORD_W       : width of one stored word in bits
//   - LAT_MIN/MAX  : legal range of the access latency parameter
//   - DEPTH_MIN/MAX: legal range of the storage depth parameter
//   - CNT_W        : width of the latency down-counter
//   - word_aligned : true when a byte address points at a word boundary
`timescale 1ns/1ps
package dmem_pkg;

    localparam int WORD_W    = 64;
    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 8;
    localparam int DEPTH_MIN = 16;
    localparam int DEPTH_MAX = 1024;

    // Counter is loaded with LAT-1, so LAT_MAX-1 must fit.
    localparam int CNT_W = $clog2(LAT_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic word_aligned(input logic [2:0] byte_lsb);
        return byte_lsb == 3'b000;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x WORD_W storage with a synchronous write port and a
// registered read port. The stored words have no reset; only the read
// output register is cleared by reset.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset of the read output register
//   we     : write enable, commits wdata to mem[waddr] on the rising edge
//   waddr  : write word index
//   wdata  : write data
//   re     : read enable, updates rdata on the rising edge
//   raddr  : read word index
//   rzero  : when set with re, rdata loads zero instead of the stored word
//   rdata  : registered read data; holds its value while re is low
`timescale 1ns/1ps
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    input  logic              rzero,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle data memory behind the MEM stage.
// A request seen in IDLE stalls the pipeline at once, is latched, and is
// serviced after LAT cycles in BUSY; the result is presented for one cycle
// in DONE, where stall is already released.
//
// Handshake: a request (mem_read or mem_write high) is accepted in the
// cycle the FSM is in IDLE; stall is high from that cycle through the last
// BUSY cycle (LAT+1 cycles). The requester must hold its request while
// stall is high; inputs are ignored outside IDLE. rdata_valid marks the one
// DONE cycle of a read. Read and write together count as a write.
//
// Build option: define DMEM_ALIGN_CHECK_EN to add the mem_err port and
// reject requests whose addr[2:0] is non-zero (write dropped, read returns
// zero). Without it addr[2:0] is ignored.
//
// Ports:
//   clk         : clock
//   pc_reset_n  : asynchronous active-low reset
//   mem_read    : read request
//   mem_write   : write request
//   addr        : byte address; word index is addr[3 +: log2(DEPTH)]
//   wdata       : store data
//   rdata       : load data, holds until the next completed read
//   rdata_valid : high in DONE of a read
//   stall       : pipeline hold
//   dbg_state   : current FSM state
//   mem_err     : misaligned-access pulse in DONE (DMEM_ALIGN_CHECK_EN only)
`timescale 1ns/1ps
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int LAT   = 2
) (
    input  logic              clk,
    input  logic              pc_reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              stall,
    output state_t            dbg_state
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic              mem_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  wdata_q;
    logic               write_q;
    logic               misaligned_q;

    logic               req;
    logic               accept;
    logic               finish;
    logic               arr_we;
    logic               arr_re;

    assign req    = mem_read | mem_write;
    assign accept = (state == IDLE) && req;
    // Last BUSY cycle: the edge that ends it moves the FSM to DONE.
    assign finish = (state == BUSY) && (cnt == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = BUSY;
            BUSY:    if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Latency counter and request latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_W'(LAT - 1);
            idx_q   <= addr[3 +: IDX_W];
            wdata_q <= wdata;
            // A simultaneous read and write resolves to the write.
            write_q <= mem_write;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            misaligned_q <= 1'b0;
        end else if (accept) begin
            misaligned_q <= !word_aligned(addr[2:0]);
        end
    end

    // Address bits above the word index only alias the storage.
    logic unused_addr;
    assign unused_addr = ^addr[WORD_W-1:3+IDX_W];
`else
    assign misaligned_q = 1'b0;

    // Byte offset and bits above the word index do not select storage.
    logic unused_addr;
    assign unused_addr = ^{addr[WORD_W-1:3+IDX_W], addr[2:0]};
`endif

    // Storage is touched only on the BUSY-to-DONE edge, so a reset taken
    // during BUSY drops the pending access without side effects.
    assign arr_we = finish && write_q && !misaligned_q;
    assign arr_re = finish && !write_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (pc_reset_n),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .re    (arr_re),
        .raddr (idx_q),
        .rzero (misaligned_q),
        .rdata (rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        // The request term is combinational, so gate it with reset to keep
        // stall low while reset is held.
        stall       = pc_reset_n && (accept || (state == BUSY));
        rdata_valid = (state == DONE) && !write_q;
        dbg_state   = state;
`ifdef DMEM_ALIGN_CHECK_EN
        mem_err     = (state == DONE) && misaligned_q;
`endif
    end

endmodule

// File: tb/tb_data_memory_responder.sv
`timescale 1ns/1ps
module tb_data_memory_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;
    localparam int WIN   = 12;   // cycles observed per transaction
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [63:0] addr, wdata;

    logic [63:0] rdata, rdata_l1, rdata_l8;
    logic        rdata_valid, valid_l1, valid_l8;
    logic        stall, stall_l1, stall_l8;
    state_t      st, st_l1, st_l8;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        mem_err, err_l1, err_l8;
`endif

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH(DEPTH), .LAT(LAT)) u_dut (
        .clk(clk), .pc_reset_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .stall(stall), .dbg_state(st)
`ifdef DMEM_ALIGN_CHECK_EN
        , .mem_err(mem_err)
`endif
    );

    data_memory_responder #(.DEPTH(DEPTH), .LAT(1)) u_lat1 (
        .clk(clk), .pc_reset_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata_l1), .rdata_valid(valid_l1),
        .stall(stall_l1), .dbg_state(st_l1)
`ifdef DMEM_ALIGN_CHECK_EN
        , .mem_err(err_l1)
`endif
    );

    data_memory_responder #(.DEPTH(DEPTH), .LAT(8)) u_lat8 (
        .clk(clk), .pc_reset_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata_l8), .rdata_valid(valid_l8),
        .stall(stall_l8), .dbg_state(st_l8)
`ifdef DMEM_ALIGN_CHECK_EN
        , .mem_err(err_l8)
`endif
    );

    // ---------------- counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // Word-addressed memory seen through byte addresses modulo DEPTH*8.
    logic [63:0] model_mem [DEPTH];
    bit          model_known [DEPTH];
    logic [63:0] model_rdata = 64'd0;
    logic [63:0] exp_q [$];

    function automatic int model_idx(input logic [63:0] a);
        return int'((a / 8) % DEPTH);
    endfunction

    function automatic bit model_misaligned(input logic [63:0] a);
        return ALIGN_EN && ((a % 8) != 0);
    endfunction

    task automatic model_apply(input bit rd, input bit wr, input logic [63:0] a,
                               input logic [63:0] d, output bit exp_valid,
                               output bit exp_err);
        int i;
        bit mis;
        i = model_idx(a);
        mis = model_misaligned(a);
        exp_err   = mis && (rd || wr);
        exp_valid = rd && !wr;
        if (wr) begin
            if (!mis) begin
                model_mem[i]   = d;
                model_known[i] = 1'b1;
            end
        end else if (rd) begin
            model_rdata = mis ? 64'd0 : model_mem[i];
        end
    endtask

    // ---------------- driver / monitor ----------------
    int          m_stall_len, m_stall1_len, m_stall8_len;
    int          m_done_idx, m_valid_cnt, m_err_cnt;
    bit          m_valid_done, m_err_done, m_rdata_early;
    logic [63:0] m_rdata_pre, m_rdata_done, m_rdata_end;
    state_t      m_state_done;

    task automatic run_txn(input bit rd, input bit wr, input logic [63:0] a,
                           input logic [63:0] d);
        m_stall_len = 0; m_stall1_len = 0; m_stall8_len = 0;
        m_done_idx = -1; m_valid_cnt = 0; m_err_cnt = 0;
        m_valid_done = 1'b0; m_err_done = 1'b0; m_rdata_early = 1'b0;
        m_rdata_done = 'x; m_state_done = IDLE;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        for (int c = 0; c < WIN; c++) begin
            if (c > 0) begin
                @(negedge clk);
                // Drop the request and scramble the buses: must be ignored.
                mem_read = 1'b0; mem_write = 1'b0;
                addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
            end
            #1;
            if (c == 0) m_rdata_pre = rdata;
            if (stall)       m_stall_len++;
            if (stall_l1)    m_stall1_len++;
            if (stall_l8)    m_stall8_len++;
            if (rdata_valid) m_valid_cnt++;
`ifdef DMEM_ALIGN_CHECK_EN
            if (mem_err)     m_err_cnt++;
`endif
            if (m_done_idx < 0 && !stall) begin
                m_done_idx   = c;
                m_valid_done = rdata_valid;
                m_rdata_done = rdata;
                m_state_done = st;
`ifdef DMEM_ALIGN_CHECK_EN
                m_err_done   = mem_err;
`endif
            end
            if (m_done_idx < 0 && rdata !== m_rdata_pre) m_rdata_early = 1'b1;
        end
        m_rdata_end = rdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; addr = 64'h10; wdata = 64'd0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_tests++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_tests++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rdata_valid); end
        n_tests++; if (st !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", st, IDLE); end
`ifdef DMEM_ALIGN_CHECK_EN
        n_tests++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", mem_err); end
`endif
        repeat (2) @(negedge clk);
        mem_read = 1'b0;
        rst_n = 1'b1;
        model_rdata = 64'd0;
    endtask

    task automatic test_write_read();
        bit ev, ee;
        logic [63:0] prev;
        prev = model_rdata;
        model_apply(1'b0, 1'b1, 64'h10, 64'hDEADBEEF00000001, ev, ee);
        run_txn(1'b0, 1'b1, 64'h10, 64'hDEADBEEF00000001);
        n_tests++; if (m_stall_len !== LAT + 1) begin n_fail++; $display("FAIL wr_stall_len: got %0d expected %0d", m_stall_len, LAT + 1); end
        n_tests++; if (m_done_idx !== LAT + 1) begin n_fail++; $display("FAIL wr_done_cycle: got %0d expected %0d", m_done_idx, LAT + 1); end
        n_tests++; if (m_state_done !== DONE) begin n_fail++; $display("FAIL wr_done_state: got %0d expected %0d", m_state_done, DONE); end
        n_tests++; if (m_valid_cnt !== 0) begin n_fail++; $display("FAIL wr_valid_cnt: got %0d expected 0", m_valid_cnt); end
        n_tests++; if (m_rdata_end !== prev) begin n_fail++; $display("FAIL wr_rdata_hold: got %h expected %h", m_rdata_end, prev); end

        model_apply(1'b1, 1'b0, 64'h10, 64'd0, ev, ee);
        run_txn(1'b1, 1'b0, 64'h10, 64'd0);
        n_tests++; if (m_stall_len !== LAT + 1) begin n_fail++; $display("FAIL rd_stall_len: got %0d expected %0d", m_stall_len, LAT + 1); end
        n_tests++; if (m_valid_done !== 1'b1) begin n_fail++; $display("FAIL rd_valid_done: got %b expected 1", m_valid_done); end
        n_tests++; if (m_valid_cnt !== 1) begin n_fail++; $display("FAIL rd_valid_cnt: got %0d expected 1", m_valid_cnt); end
        n_tests++; if (m_rdata_done !== 64'hDEADBEEF00000001) begin n_fail++; $display("FAIL rd_data: got %h expected %h", m_rdata_done, 64'hDEADBEEF00000001); end
        n_tests++; if (m_rdata_early !== 1'b0) begin n_fail++; $display("FAIL rd_data_early: got %b expected 0", m_rdata_early); end
        n_tests++; if (m_rdata_end !== model_rdata) begin n_fail++; $display("FAIL rd_data_hold: got %h expected %h", m_rdata_end, model_rdata); end
    endtask

    task automatic test_wrap();
        bit ev, ee;
        model_apply(1'b0, 1'b1, 64'h400, 64'h55, ev, ee);
        run_txn(1'b0, 1'b1, 64'h400, 64'h55);
        model_apply(1'b1, 1'b0, 64'h0, 64'd0, ev, ee);
        run_txn(1'b1, 1'b0, 64'h0, 64'd0);
        n_tests++; if (m_rdata_done !== model_rdata) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", m_rdata_done, model_rdata); end
        n_tests++; if (m_valid_done !== ev) begin n_fail++; $display("FAIL wrap_valid: got %b expected %b", m_valid_done, ev); end
    endtask

    task automatic test_simultaneous();
        bit ev, ee;
        logic [63:0] prev;
        prev = model_rdata;
        model_apply(1'b1, 1'b1, 64'h8, 64'h7, ev, ee);
        run_txn(1'b1, 1'b1, 64'h8, 64'h7);
        n_tests++; if (m_valid_cnt !== 0) begin n_fail++; $display("FAIL both_valid_cnt: got %0d expected 0", m_valid_cnt); end
        n_tests++; if (m_rdata_end !== prev) begin n_fail++; $display("FAIL both_rdata_hold: got %h expected %h", m_rdata_end, prev); end
        n_tests++; if (m_stall_len !== LAT + 1) begin n_fail++; $display("FAIL both_stall_len: got %0d expected %0d", m_stall_len, LAT + 1); end
        model_apply(1'b1, 1'b0, 64'h8, 64'd0, ev, ee);
        run_txn(1'b1, 1'b0, 64'h8, 64'd0);
        n_tests++; if (m_rdata_done !== model_rdata) begin n_fail++; $display("FAIL both_stored: got %h expected %h", m_rdata_done, model_rdata); end
    endtask

    task automatic test_idle();
        bit ev, ee;
        logic [63:0] prev;
        prev = model_rdata;
        run_txn(1'b0, 1'b0, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF);
        n_tests++; if (m_stall_len !== 0) begin n_fail++; $display("FAIL idle_stall: got %0d expected 0", m_stall_len); end
        n_tests++; if (m_rdata_end !== prev) begin n_fail++; $display("FAIL idle_rdata: got %h expected %h", m_rdata_end, prev); end
        model_apply(1'b1, 1'b0, 64'h8, 64'd0, ev, ee);
        run_txn(1'b1, 1'b0, 64'h8, 64'd0);
        n_tests++; if (m_rdata_done !== model_rdata) begin n_fail++; $display("FAIL idle_storage: got %h expected %h", m_rdata_done, model_rdata); end
    endtask

    task automatic test_reset_mid_op();
        bit ev, ee;
        model_apply(1'b0, 1'b1, 64'h20, 64'h1234_5678_9ABC_DEF0, ev, ee);
        run_txn(1'b0, 1'b1, 64'h20, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; addr = 64'h20; wdata = 64'hAA;
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        n_tests++; if (st !== BUSY) begin n_fail++; $display("FAIL rst_mid_busy: got %0d expected %0d", st, BUSY); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b expected 0", stall); end
        n_tests++; if (st !== IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected %0d", st, IDLE); end
        n_tests++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected 0", rdata); end
        model_rdata = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        model_apply(1'b1, 1'b0, 64'h20, 64'd0, ev, ee);
        run_txn(1'b1, 1'b0, 64'h20, 64'd0);
        n_tests++; if (m_rdata_done !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL rst_mid_data: got %h expected %h", m_rdata_done, 64'h1234_5678_9ABC_DEF0); end
        n_tests++; if (m_stall_len !== LAT + 1) begin n_fail++; $display("FAIL rst_mid_first_req: got %0d expected %0d", m_stall_len, LAT + 1); end
    endtask

    task automatic test_alignment();
        bit ev, ee;
        logic [63:0] want;
        model_apply(1'b0, 1'b1, 64'h10, 64'h1111, ev, ee);
        run_txn(1'b0, 1'b1, 64'h10, 64'h1111);
        model_apply(1'b0, 1'b1, 64'h13, 64'h2222, ev, ee);
        run_txn(1'b0, 1'b1, 64'h13, 64'h2222);
`ifdef DMEM_ALIGN_CHECK_EN
        n_tests++; if (m_err_cnt !== 1) begin n_fail++; $display("FAIL align_err_cnt: got %0d expected 1", m_err_cnt); end
        n_tests++; if (m_err_done !== 1'b1) begin n_fail++; $display("FAIL align_err_done: got %b expected 1", m_err_done); end
`endif
        want = ALIGN_EN ? 64'h1111 : 64'h2222;
        model_apply(1'b1, 1'b0, 64'h10, 64'd0, ev, ee);
        run_txn(1'b1, 1'b0, 64'h10, 64'd0);
        n_tests++; if (m_rdata_done !== want) begin n_fail++; $display("FAIL align_storage: got %h expected %h", m_rdata_done, want); end
        model_apply(1'b1, 1'b0, 64'h15, 64'd0, ev, ee);
        run_txn(1'b1, 1'b0, 64'h15, 64'd0);
        n_tests++; if (m_rdata_done !== model_rdata) begin n_fail++; $display("FAIL align_read: got %h expected %h", m_rdata_done, model_rdata); end
        n_tests++; if (m_valid_done !== 1'b1) begin n_fail++; $display("FAIL align_read_valid: got %b expected 1", m_valid_done); end
    endtask

    task automatic test_lat_sweep();
        bit ev, ee;
        model_apply(1'b1, 1'b0, 64'h10, 64'd0, ev, ee);
        run_txn(1'b1, 1'b0, 64'h10, 64'd0);
        n_tests++; if (m_stall1_len !== 2) begin n_fail++; $display("FAIL lat1_stall_len: got %0d expected 2", m_stall1_len); end
        n_tests++; if (m_stall8_len !== 9) begin n_fail++; $display("FAIL lat8_stall_len: got %0d expected 9", m_stall8_len); end
        n_tests++; if (m_stall_len !== 3) begin n_fail++; $display("FAIL lat2_stall_len: got %0d expected 3", m_stall_len); end
    endtask

    task automatic test_random();
        bit ev, ee, rd, wr;
        int op;
        logic [63:0] a, d, exp_rd;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 3);
            rd = (op >= 2);
            wr = (op != 2);
            a  = {$urandom, $urandom};
            if (ALIGN_EN && $urandom_range(0, 3) != 0) a = a - (a % 8);
            d  = {$urandom, $urandom};
            if (rd && !wr && !model_misaligned(a) && !model_known[model_idx(a)]) wr = 1'b1;
            model_apply(rd, wr, a, d, ev, ee);
            exp_q.push_back(model_rdata);
            run_txn(rd, wr, a, d);
            exp_rd = exp_q.pop_front();
            n_tests++; if (m_rdata_done !== exp_rd) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, m_rdata_done, exp_rd); end
            n_tests++; if (m_valid_cnt !== int'(ev)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %0d expected %0d", n, m_valid_cnt, ev); end
            n_tests++; if (m_stall_len !== LAT + 1) begin n_fail++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", n, m_stall_len, LAT + 1); end
`ifdef DMEM_ALIGN_CHECK_EN
            n_tests++; if (m_err_cnt !== int'(ee)) begin n_fail++; $display("FAIL rand_err[%0d]: got %0d expected %0d", n, m_err_cnt, ee); end
`endif
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
        test_reset();
        test_write_read();
        test_wrap();
        test_simultaneous();
        test_idle();
        test_reset_mid_op();
        test_alignment();
        test_lat_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
